// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and default sizing for the single-port RAM controller.
// The CLEAR state is always present in the enum. It is only reachable
// when the design is built with RAM_CLEAR_EN defined.
package sp_ram_ctrl_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 64;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WRITE,
      READ,
      RESP
   } state_t;

endpackage

// File: rtl/sp_ram_clear_seq.sv
// Address sweep counter for the memory clear, with terminal detect.
// It is instantiated by sp_ram_ctrl only when RAM_CLEAR_EN is defined.
// The sweep ends on an explicit compare against DEPTH-1. It never relies on
// counter wrap, so a DEPTH that is not a power of two is handled correctly.
module sp_ram_clear_seq
   import sp_ram_ctrl_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_BUS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                step,
   output logic                last,
   output logic [ADDR_BUS-1:0] next_addr
);

   localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);
   localparam logic [ADDR_BUS-1:0] ONE       = ADDR_BUS'(1);

   logic [ADDR_BUS-1:0] cnt;

   // Counter tracks the address currently being cleared; restarts at 0 on start
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= cnt + ONE;
      end
   end

   assign last      = (cnt == LAST_ADDR);
   assign next_addr = cnt + ONE;

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller.
// It turns req/rsp handshakes into cycles on a downstream asynchronous RAM.
// All RAM-side outputs, and the handshake outputs, are registered.
// Optional feature: define RAM_CLEAR_EN to add the CLEAR sweep. The sweep
// writes zero to every word after reset and whenever clr_req is pulsed in IDLE.
module sp_ram_ctrl
   import sp_ram_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_BUS = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_BUS-1:0] req_addr,
   input  logic [WIDTH-1:0]    req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WIDTH-1:0]    rsp_rdata,
   input  logic                clr_req,
   output logic                busy,
   output logic [ADDR_BUS-1:0] ram_addr,
   output logic [WIDTH-1:0]    ram_din,
   output logic                ram_we,
   input  logic [WIDTH-1:0]    ram_dout
);

   state_t state;
   logic   hs;

   // req_ready is only ever high in IDLE, so hs implies IDLE
   assign hs = req_valid & req_ready;

`ifdef RAM_CLEAR_EN
   logic                init_clr;
   logic                clr_go;
   logic                clr_step;
   logic                clr_last;
   logic [ADDR_BUS-1:0] clr_next;

   // A clear starts from IDLE on request, or once right after reset
   assign clr_go   = (state == IDLE) & (clr_req | init_clr);
   assign clr_step = (state == CLEAR) & ~clr_last;

   sp_ram_clear_seq #(
      .DEPTH    (DEPTH),
      .ADDR_BUS (ADDR_BUS)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .start     (clr_go),
      .step      (clr_step),
      .last      (clr_last),
      .next_addr (clr_next)
   );
`else
   logic unused_clr;

   assign unused_clr = clr_req;
   assign busy       = 1'b0;
`endif

   // Controller FSM; every output is registered together with the state it belongs to
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
`ifdef RAM_CLEAR_EN
         busy      <= 1'b0;
         init_clr  <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef RAM_CLEAR_EN
               if (clr_go) begin
                  // Clear wins over a simultaneous request, which stays pending
                  state     <= CLEAR;
                  init_clr  <= 1'b0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  ram_we    <= 1'b1;
                  ram_addr  <= '0;
                  ram_din   <= '0;
               end else if (hs) begin
`else
               if (hs) begin
`endif
                  req_ready <= 1'b0;
                  ram_addr  <= req_addr;
                  if (req_we) begin
                     state   <= WRITE;
                     ram_we  <= 1'b1;
                     ram_din <= req_wdata;
                  end else begin
                     state   <= READ;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end

            WRITE: begin
               state     <= IDLE;
               ram_we    <= 1'b0;
               req_ready <= 1'b1;
            end

            READ: begin
               // RAM read is combinational; address has been stable all cycle
               state     <= RESP;
               rsp_rdata <= ram_dout;
               rsp_valid <= 1'b1;
            end

            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end

`ifdef RAM_CLEAR_EN
            CLEAR: begin
               if (clr_last) begin
                  state     <= IDLE;
                  ram_we    <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  ram_addr  <= clr_next;
               end
            end
`endif

            default: begin
               state     <= IDLE;
               ram_we    <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Testbench for sp_ram_ctrl: behavioural async RAM, table vectors,
// hand-written corner sequences and randomized traffic against a shadow memory.
// Sections depending on RAM_CLEAR_EN follow the same macro as the design.
module tb_sp_ram_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [AW-1:0]    req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;
   logic             clr_req;
   logic             busy;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_din;
   logic             ram_we;
   logic [WIDTH-1:0] ram_dout;

   always #5 clk = ~clk;

   sp_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .clr_req   (clr_req),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   // Behavioural asynchronous RAM with a bench-controlled bulk preload
   logic [WIDTH-1:0] mem [DEPTH];
   logic             preload;
   logic [WIDTH-1:0] preload_val;
   int               wr_cnt = 0;

   assign ram_dout = mem[ram_addr];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= preload_val;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
   end

   always @(posedge clk) if (ram_we) wr_cnt <= wr_cnt + 1;

   // Reference model: what each word should hold after the accepted operations
   logic [WIDTH-1:0] ref_mem [DEPTH];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check({tag, "_ram_we"},    ram_we,    0);
      check({tag, "_ram_addr"},  ram_addr,  0);
      check({tag, "_ram_din"},   ram_din,   0);
      check({tag, "_busy"},      busy,      0);
   endtask

   task automatic ref_fill(input logic [WIDTH-1:0] v);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("wait_req_ready", req_ready, 1);
   endtask

   task automatic wait_clear_done();
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("wait_busy_fall", busy, 0);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      int w0;
      wait_ready();
      rsp_ready = 1'($urandom_range(0, 1));
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      check("wr_ram_we",    ram_we,    1);
      check("wr_ram_addr",  ram_addr,  a);
      check("wr_ram_din",   ram_din,   d);
      check("wr_req_ready", req_ready, 0);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("wr_ram_we_drop", ram_we,      0);
      check("wr_one_write",   wr_cnt - w0, 1);
      check("wr_no_rsp",      rsp_valid,   0);
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input int hold);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_ram_addr",   ram_addr,  a);
      check("rd_ram_we",     ram_we,    0);
      check("rd_rsp_early",  rsp_valid, 0);
      @(negedge clk);
      check("rd_rsp_valid",  rsp_valid, 1);
      check("rd_rsp_rdata",  rsp_rdata, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rd_hold_valid", rsp_valid, 1);
         check("rd_hold_rdata", rsp_rdata, exp);
         check("rd_hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rd_rsp_drop",  rsp_valid, 0);
      check("rd_req_ready", req_ready, 1);
   endtask

   typedef struct {
      bit               we;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] wdata;
      logic [WIDTH-1:0] exp;
      int               hold;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int n;
      int bc;
      int bad;
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rd;

      tbl[0] = '{1'b1, 6'd5,  8'hA5, 8'h00, 0};
      tbl[1] = '{1'b0, 6'd5,  8'h00, 8'hA5, 0};
      tbl[2] = '{1'b1, 6'd0,  8'h3C, 8'h00, 0};
      tbl[3] = '{1'b1, 6'd63, 8'hC3, 8'h00, 0};
      tbl[4] = '{1'b1, 6'd9,  8'h96, 8'h00, 0};
      tbl[5] = '{1'b0, 6'd9,  8'h00, 8'h96, 4};
      tbl[6] = '{1'b0, 6'd0,  8'h00, 8'h3C, 1};
      tbl[7] = '{1'b0, 6'd63, 8'h00, 8'hC3, 2};
      tbl[8] = '{1'b1, 6'd5,  8'h5A, 8'h00, 0};
      tbl[9] = '{1'b0, 6'd5,  8'h00, 8'h5A, 0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; clr_req = 1'b0; preload = 1'b1; preload_val = '0;
      ref_fill(8'h00);
      repeat (3) @(negedge clk);
      preload = 1'b0;
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
`ifdef RAM_CLEAR_EN
      check("post_reset_busy",   busy,   1);
      check("post_reset_ram_we", ram_we, 1);
      wait_clear_done();
`else
      check("post_reset_req_ready", req_ready, 1);
      check("post_reset_busy",      busy,      0);
`endif

      // Table-driven directed vectors
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) do_write(tbl[i].addr, tbl[i].wdata);
         else           do_read(tbl[i].addr, tbl[i].exp, tbl[i].hold);
      end

`ifdef RAM_CLEAR_EN
      // Full clear over a memory preloaded with 0xFF
      wait_ready();
      preload = 1'b1; preload_val = 8'hFF;
      @(negedge clk);
      preload = 1'b0;
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      bc = 0; n = 0;
      while (busy && n < 300) begin
         bc++; n++;
         @(negedge clk);
      end
      check("clear_busy_cycles", bc, 64);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) bad++;
      check("clear_nonzero_words", bad, 0);
      ref_fill(8'h00);
      do_read(6'd63, 8'h00, 0);

      // Clear and request in the same IDLE cycle: clear first, request after
      wait_ready();
      clr_req = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wdata = 8'h77;
      @(negedge clk);
      clr_req = 1'b0;
      check("clr_prio_busy",     busy,     1);
      check("clr_prio_ram_addr", ram_addr, 0);
      check("clr_prio_ram_din",  ram_din,  0);
      n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("clr_prio_busy_fell", busy, 0);
      @(negedge clk);
      req_valid = 1'b0;
      check("clr_prio_wr_we",   ram_we,   1);
      check("clr_prio_wr_addr", ram_addr, 7);
      check("clr_prio_wr_din",  ram_din,  8'h77);
      @(negedge clk);
      ref_mem[7] = 8'h77;
      check("clr_prio_mem", mem[7], 8'h77);

      // Reset in the middle of a clear sweep
      wait_ready();
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      n = 0;
      while (ram_addr != 6'd20 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("midclr_at_20", ram_addr, 20);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("midclr_rst");
      w0 = wr_cnt;
      repeat (3) @(negedge clk);
      check("midclr_no_writes", wr_cnt - w0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midclr_restart", busy, 1);
      wait_clear_done();
      ref_fill(8'h00);
`else
      // clr_req must be ignored without the clear feature
      wait_ready();
      w0 = wr_cnt;
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("noclr_busy", busy, 0);
         @(negedge clk);
      end
      check("noclr_no_writes", wr_cnt - w0, 0);
      check("noclr_req_ready", req_ready, 1);
`endif

      // Reset while a response is pending
      do_write(6'd9, 8'h3E);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd9; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("resp_rst_pending", rsp_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("resp_rst");
      rst = 1'b0;
      @(negedge clk);
`ifdef RAM_CLEAR_EN
      wait_clear_done();
      ref_fill(8'h00);
`else
      check("resp_rst_ready", req_ready, 1);
      check("resp_rst_no_rsp", rsp_valid, 0);
`endif

      // Randomized traffic checked against the shadow memory
      for (int k = 0; k < 60; k++) begin
         ra = AW'($urandom_range(0, DEPTH - 1));
         rd = WIDTH'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(ra, rd);
         else                           do_read(ra, ref_mem[ra], int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("final_mem_compare", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
